nuc_window_matcher: RTL and testbench
=====================================

Name: nuc_window_matcher

Overview:
Streams 2-bit nucleotides from a combinational-read nucleotide memory and slides a PAT_LEN-wide window across them. Each window position is compared against a per-run pattern with a per-position care mask and a programmable mismatch tolerance. The block counts hits and records the first hit address. It sits between the nucleotide memory and the lab's pattern-search control/display logic, and replaces ad-hoc exact-match scanning.

Parameters:
PAT_LEN, 8, pattern/window length in nucleotides (>=2)
AW, 16, nucleotide memory address width
CNT_W, 16, match counter width (saturating)
MMW, $clog2(PAT_LEN+1), width of mismatch tolerance and mismatch tally

Ports:
clock  input  1  system clock, all state updates on posedge
reset  input  1  synchronous, active-high; returns block to IDLE
start  input  1  begin a scan when IDLE; ignored otherwise
base_addr  input  AW  first nucleotide address of the scan
seq_len  input  AW  number of nucleotides to scan
pat  input  2*PAT_LEN  pattern; pat[2k+1:2k] = nucleotide k (k=0 is earliest); A=00 C=01 G=10 T=11
pat_mask  input  PAT_LEN  1 = position k compared, 0 = wildcard
max_mm  input  MMW  hit if masked mismatches <= max_mm
nuc_re  output  1  memory read enable
nuc_addr  output  AW  memory address
nuc_data  input  2  memory read data, valid combinationally in same cycle as nuc_addr
busy  output  1  high in SCAN
done  output  1  one-cycle pulse at end of scan
found  output  1  at least one hit in last scan
match_count  output  CNT_W  hits in last scan, saturates at all-ones
first_addr  output  AW  start address of first hit window (0 if none)

Behaviour:
- Reset (sync, high): state=IDLE; busy=0, done=0, found=0, match_count=0, first_addr=0, nuc_re=0, nuc_addr=0; window cleared. Reset mid-scan aborts immediately, no done pulse.
- States: IDLE, SCAN, DONE.
- IDLE: start=1 -> latch base_addr, seq_len, pat, pat_mask, max_mm; clear found/match_count/first_addr/window; idx=0. seq_len=0 -> DONE, else SCAN. Inputs changing after start have no effect on the run.
- SCAN: nuc_re=1, nuc_addr=base+idx (AW-bit wrap-around permitted). Each edge: window <= {nuc_data, window[2*PAT_LEN-1:2]}, so window slot k holds nucleotide at address base+idx-(PAT_LEN-1)+k.
- Evaluation uses the next-window value in the same cycle: if idx >= PAT_LEN-1, mismatches = count of k with pat_mask[k]=1 and slot k != pat nucleotide k; hit iff mismatches <= max_mm. On hit: match_count++ (hold at 2^CNT_W-1); if found=0, first_addr <= base+idx-(PAT_LEN-1), found <= 1.
- idx == seq_len-1 at the edge -> DONE; else idx++.
- seq_len < PAT_LEN: full read sweep, no evaluation, count 0.
- pat_mask=0 or max_mm >= PAT_LEN: every full window is a hit.
- DONE: done=1, busy=0, nuc_re=0 for exactly one cycle; -> IDLE. start in DONE ignored.
- Results (found, match_count, first_addr) hold until next accepted start or reset.
- Latency: start edge -> busy high next cycle; done high seq_len+1 cycles after start edge (1 cycle for seq_len=0).
- start while busy: ignored, no effect on the run in progress.

Test Plan:
- PAT_LEN=4; memory ACGTACGT at base 0; pat=ACGT, mask=1111, max_mm=0, seq_len=8 -> done 9 cycles after start, match_count=2, found=1, first_addr=0; nuc_addr steps 0..7.
- Same memory; pat=AAGT, max_mm=1 -> count=2, first_addr=0; max_mm=0 -> count=0, found=0, first_addr=0.
- Same memory; pat=ACTT, mask=1011 (position 2 wildcard... i.e. pat_mask[2]=0), max_mm=0 -> count=2, first_addr=0.
- seq_len=3 -> done after 4 cycles, count 0; seq_len=0 -> done next cycle, nuc_re never high.
- CNT_W=2, ten A's, pat=AAAA -> 7 hits saturate: match_count=3, first_addr=0; pulse start mid-scan -> ignored.
- Assert reset on cycle 3 of a scan -> next cycle IDLE, all outputs 0, no done pulse; new start then completes normally.

Source files
------------

// File: rtl/nuc_window_matcher.sv
// Sliding-window nucleotide matcher: streams 2-bit bases from memory and scores
// each PAT_LEN-wide window against a masked pattern with a mismatch tolerance.
module nuc_window_matcher #(
    parameter int PAT_LEN = 8,
    parameter int AW      = 16,
    parameter int CNT_W   = 16,
    parameter int MMW     = $clog2(PAT_LEN + 1)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [AW-1:0]        base_addr,
    input  logic [AW-1:0]        seq_len,
    input  logic [2*PAT_LEN-1:0] pat,
    input  logic [PAT_LEN-1:0]   pat_mask,
    input  logic [MMW-1:0]       max_mm,
    output logic                 nuc_re,
    output logic [AW-1:0]        nuc_addr,
    input  logic [1:0]           nuc_data,
    output logic                 busy,
    output logic                 done,
    output logic                 found,
    output logic [CNT_W-1:0]     match_count,
    output logic [AW-1:0]        first_addr
);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t               state_q, state_d;
    logic [AW-1:0]        baseAddr_q, baseAddr_d;
    logic [AW-1:0]        seqLen_q, seqLen_d;
    logic [2*PAT_LEN-1:0] pattern_q, pattern_d;
    logic [PAT_LEN-1:0]   careMask_q, careMask_d;
    logic [MMW-1:0]       maxMm_q, maxMm_d;
    logic [AW-1:0]        idx_q, idx_d;
    logic [2*PAT_LEN-1:0] window_q, window_d;
    logic                 found_q, found_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [AW-1:0]        firstAddr_q, firstAddr_d;

    logic [2*PAT_LEN-1:0] windowNext;
    logic [MMW-1:0]       mmTally;
    logic                 windowFull;
    logic                 hit;
    logic                 lastIdx;

    // Scoring looks at the window as it will be after this edge's shift-in.
    assign windowNext = {nuc_data, window_q[2*PAT_LEN-1:2]};

    always_comb begin
        mmTally = '0;
        for (int k = 0; k < PAT_LEN; k++) begin
            if (careMask_q[k] && (windowNext[2*k +: 2] != pattern_q[2*k +: 2])) begin
                mmTally = mmTally + MMW'(1);
            end
        end
    end

    assign windowFull = (idx_q >= AW'(PAT_LEN - 1));
    assign hit        = (state_q == SCAN) && windowFull && (mmTally <= maxMm_q);
    assign lastIdx    = (idx_q == (seqLen_q - AW'(1)));

    always_comb begin
        state_d     = state_q;
        baseAddr_d  = baseAddr_q;
        seqLen_d    = seqLen_q;
        pattern_d   = pattern_q;
        careMask_d  = careMask_q;
        maxMm_d     = maxMm_q;
        idx_d       = idx_q;
        window_d    = window_q;
        found_d     = found_q;
        count_d     = count_q;
        firstAddr_d = firstAddr_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    baseAddr_d  = base_addr;
                    seqLen_d    = seq_len;
                    pattern_d   = pat;
                    careMask_d  = pat_mask;
                    maxMm_d     = max_mm;
                    idx_d       = '0;
                    window_d    = '0;
                    found_d     = 1'b0;
                    count_d     = '0;
                    firstAddr_d = '0;
                    state_d     = (seq_len == '0) ? DONE : SCAN;
                end
            end
            SCAN: begin
                window_d = windowNext;
                if (hit) begin
                    if (count_q != '1) begin
                        count_d = count_q + CNT_W'(1);
                    end
                    if (!found_q) begin
                        found_d     = 1'b1;
                        firstAddr_d = baseAddr_q + idx_q - AW'(PAT_LEN - 1);
                    end
                end
                if (lastIdx) begin
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + AW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            baseAddr_q  <= '0;
            seqLen_q    <= '0;
            pattern_q   <= '0;
            careMask_q  <= '0;
            maxMm_q     <= '0;
            idx_q       <= '0;
            window_q    <= '0;
            found_q     <= 1'b0;
            count_q     <= '0;
            firstAddr_q <= '0;
        end else begin
            state_q     <= state_d;
            baseAddr_q  <= baseAddr_d;
            seqLen_q    <= seqLen_d;
            pattern_q   <= pattern_d;
            careMask_q  <= careMask_d;
            maxMm_q     <= maxMm_d;
            idx_q       <= idx_d;
            window_q    <= window_d;
            found_q     <= found_d;
            count_q     <= count_d;
            firstAddr_q <= firstAddr_d;
        end
    end

    assign busy        = (state_q == SCAN);
    assign done        = (state_q == DONE);
    assign nuc_re      = busy;
    assign nuc_addr    = busy ? (baseAddr_q + idx_q) : '0;
    assign found       = found_q;
    assign match_count = count_q;
    assign first_addr  = firstAddr_q;

endmodule

// File: tb/tb_nuc_window_matcher.sv
// Randomized scoreboard bench for nuc_window_matcher with a window-by-window
// reference model over an in-bench nucleotide memory.
module tb_nuc_window_matcher;

    localparam int PL    = 4;
    localparam int AW    = 8;
    localparam int CNT_W = 3;
    localparam int MMW   = $clog2(PL + 1);
    localparam int MEMSZ = 1 << AW;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic [AW-1:0]     base_addr = '0;
    logic [AW-1:0]     seq_len = '0;
    logic [2*PL-1:0]   pat = '0;
    logic [PL-1:0]     pat_mask = '0;
    logic [MMW-1:0]    max_mm = '0;
    logic              nuc_re;
    logic [AW-1:0]     nuc_addr;
    logic [1:0]        nuc_data;
    logic              busy;
    logic              done;
    logic              found;
    logic [CNT_W-1:0]  match_count;
    logic [AW-1:0]     first_addr;

    logic [1:0] mem [MEMSZ];
    assign nuc_data = mem[nuc_addr];

    nuc_window_matcher #(.PAT_LEN(PL), .AW(AW), .CNT_W(CNT_W)) dut (
        .clock(clock), .reset(reset), .start(start), .base_addr(base_addr),
        .seq_len(seq_len), .pat(pat), .pat_mask(pat_mask), .max_mm(max_mm),
        .nuc_re(nuc_re), .nuc_addr(nuc_addr), .nuc_data(nuc_data), .busy(busy),
        .done(done), .found(found), .match_count(match_count), .first_addr(first_addr)
    );

    always #5 clock = ~clock;

    typedef struct {
        int count;
        int found;
        int first;
        int doneCyc;
    } exp_t;

    exp_t expQ[$];
    int   addrQ[$];
    int   checks = 0;
    int   errors = 0;
    int   cycCnt = 0;

    always @(posedge clock) cycCnt <= cycCnt + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Expected results derived directly from the window/mask/tolerance rules.
    task automatic model(input int base, input int len, input logic [2*PL-1:0] p,
                         input logic [PL-1:0] m, input int mm,
                         output int cnt, output int fnd, output int fst);
        cnt = 0; fnd = 0; fst = 0;
        for (int s = 0; s + PL <= len; s++) begin
            int miss = 0;
            for (int k = 0; k < PL; k++) begin
                if (m[k] && (mem[(base + s + k) % MEMSZ] != p[2*k +: 2])) miss++;
            end
            if (miss <= mm) begin
                if (cnt < (1 << CNT_W) - 1) cnt++;
                if (fnd == 0) begin
                    fnd = 1;
                    fst = (base + s) % MEMSZ;
                end
            end
        end
    endtask

    // Monitor: memory reads and done pulses are checked against the queues.
    always @(negedge clock) begin
        if (nuc_re) begin
            if (addrQ.size() == 0) begin
                checkOutput("unexpectedRead", 32'(nuc_addr), 32'hFFFF_FFFF);
            end else begin
                checkOutput("nucAddr", 32'(nuc_addr), 32'(addrQ.pop_front()));
                checkOutput("busyDuringScan", 32'(busy), 32'd1);
            end
        end
        if (done) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpectedDone", 32'(done), 32'd0);
            end else begin
                exp_t e;
                e = expQ.pop_front();
                checkOutput("doneCycle", 32'(cycCnt), 32'(e.doneCyc));
                checkOutput("matchCount", 32'(match_count), 32'(e.count));
                checkOutput("found", 32'(found), 32'(e.found));
                checkOutput("firstAddr", 32'(first_addr), 32'(e.first));
                checkOutput("readsLeft", 32'(addrQ.size()), 32'd0);
            end
        end
    end

    task automatic checkZero(input string tag);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
        checkOutput({tag, "_done"}, 32'(done), 32'd0);
        checkOutput({tag, "_found"}, 32'(found), 32'd0);
        checkOutput({tag, "_count"}, 32'(match_count), 32'd0);
        checkOutput({tag, "_first"}, 32'(first_addr), 32'd0);
        checkOutput({tag, "_re"}, 32'(nuc_re), 32'd0);
        checkOutput({tag, "_addr"}, 32'(nuc_addr), 32'd0);
    endtask

    task automatic applyStimulus(input int base, input int len, input logic [2*PL-1:0] p,
                                 input logic [PL-1:0] m, input int mm,
                                 input bit midStart, input bit doneStart);
        int   cnt, fnd, fst;
        exp_t e;
        bit   seen;
        model(base, len, p, m, mm, cnt, fnd, fst);
        @(negedge clock);
        for (int i = 0; i < len; i++) addrQ.push_back((base + i) % MEMSZ);
        e.count = cnt; e.found = fnd; e.first = fst; e.doneCyc = cycCnt + 1 + len;
        expQ.push_back(e);
        start = 1'b1; base_addr = AW'(base); seq_len = AW'(len);
        pat = p; pat_mask = m; max_mm = MMW'(mm);
        @(posedge clock); #1;
        start = 1'b0;
        base_addr = AW'($urandom); seq_len = AW'($urandom); pat = (2*PL)'($urandom);
        pat_mask = PL'($urandom); max_mm = MMW'($urandom);
        if (midStart && len >= 6) begin
            repeat (2) @(negedge clock);
            start = 1'b1;
            @(negedge clock);
            start = 1'b0;
        end
        seen = 1'b0;
        for (int i = 0; i < len + 40; i++) begin
            @(negedge clock); #1;
            if (expQ.size() == 0) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            checkOutput("doneTimeout", 32'd0, 32'd1);
            expQ.delete();
            addrQ.delete();
        end else begin
            if (doneStart) begin
                start = 1'b1;
                @(posedge clock); #1;
                start = 1'b0;
                @(negedge clock); #1;
                checkOutput("busyAfterDoneStart", 32'(busy), 32'd0);
            end
            checkOutput("holdCount", 32'(match_count), 32'(e.count));
            checkOutput("holdFound", 32'(found), 32'(e.found));
            checkOutput("holdFirst", 32'(first_addr), 32'(e.first));
        end
    endtask

    task automatic resetMidScan(input int base, input int len);
        exp_t e;
        @(negedge clock);
        for (int i = 0; i < len; i++) addrQ.push_back((base + i) % MEMSZ);
        e.count = 0; e.found = 0; e.first = 0; e.doneCyc = 0;
        expQ.push_back(e);
        start = 1'b1; base_addr = AW'(base); seq_len = AW'(len);
        pat = 8'b00000000; pat_mask = 4'b0000; max_mm = '0;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        expQ.delete();
        addrQ.delete();
        checkZero("afterReset");
        repeat (5) @(negedge clock);
        #1;
        checkOutput("idleAfterReset", 32'(busy), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int i = 0; i < MEMSZ; i++) mem[i] = 2'($urandom_range(0, 3));
        for (int i = 0; i < 8; i++) mem[i] = 2'(i % 4);
        for (int i = 100; i < 112; i++) mem[i] = 2'b00;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock); #1;
        checkZero("reset");

        applyStimulus(0, 8, 8'b11100100, 4'b1111, 0, 1'b0, 1'b1);
        applyStimulus(0, 8, 8'b11100000, 4'b1111, 1, 1'b0, 1'b0);
        applyStimulus(0, 8, 8'b11100000, 4'b1111, 0, 1'b0, 1'b0);
        applyStimulus(0, 8, 8'b11110100, 4'b1011, 0, 1'b0, 1'b0);
        applyStimulus(0, 3, 8'b11100100, 4'b1111, 0, 1'b0, 1'b0);
        applyStimulus(0, 0, 8'b11100100, 4'b1111, 0, 1'b0, 1'b1);
        applyStimulus(100, 10, 8'b00000000, 4'b1111, 0, 1'b1, 1'b0);
        applyStimulus(100, 12, 8'b00000000, 4'b1111, 0, 1'b1, 1'b0);
        applyStimulus(0, 8, 8'b01010101, 4'b0000, 0, 1'b0, 1'b0);
        applyStimulus(0, 8, 8'b01010101, 4'b1111, 5, 1'b0, 1'b0);
        applyStimulus(250, 12, 8'b11100100, 4'b1111, 1, 1'b0, 1'b0);

        resetMidScan(0, 8);
        applyStimulus(0, 8, 8'b11100100, 4'b1111, 0, 1'b0, 1'b0);

        for (int r = 0; r < 40; r++) begin
            int len;
            if (r % 10 == 0) begin
                for (int i = 0; i < MEMSZ; i++)
                    mem[i] = (r % 20 == 0) ? 2'($urandom_range(0, 1)) : 2'($urandom_range(0, 3));
            end
            len = $urandom_range(0, 30);
            applyStimulus($urandom_range(0, MEMSZ - 1), len, (2*PL)'($urandom), PL'($urandom),
                          $urandom_range(0, 4), (len >= 6) && ($urandom_range(0, 3) == 0),
                          $urandom_range(0, 3) == 0);
        end

        repeat (3) @(negedge clock);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
